// File: rtl/vcd_stim_pkg.sv
// rtl/vcd_stim_pkg.sv - shared types and constants for the VCD stimulus sequencer
package vcd_stim_pkg;

   localparam int WIDTH = 64;
   localparam logic [WIDTH-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
   typedef enum logic [1:0] {M_WALK1, M_WALK0, M_LFSR, M_ONES} mode_t;

   // Galois LFSR, shifting right, taps folded in when the outgoing bit is one
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : {WIDTH{1'b0}});
   endfunction

endpackage

// File: rtl/vcd_pattern_gen.sv
// rtl/vcd_pattern_gen.sv - next stimulus vector for the selected mode; owns the LFSR
module vcd_pattern_gen
   import vcd_stim_pkg::*;
#(
   parameter logic [63:0] LFSR_SEED = 64'h0000_0000_0000_0001
) (
   input  logic             clk,
   input  logic             rst,
   input  mode_t            mode,
   input  logic [5:0]       index,
   input  logic             lfsr_step,
   input  logic             lfsr_load,
   output logic [WIDTH-1:0] vec
);

   localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == 64'h0) ? {WIDTH{1'b1}} : LFSR_SEED;

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;
   logic [WIDTH-1:0] one_hot;

   // lfsr_d is the value presented for the vector being loaded this edge
   always_comb begin
      lfsr_d = lfsr_q;
      if (lfsr_load)
         lfsr_d = SEED_EFF;
      else if (lfsr_step)
         lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk) begin
      if (rst)
         lfsr_q <= SEED_EFF;
      else
         lfsr_q <= lfsr_d;
   end

   assign one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << index;

   always_comb begin
      vec = {WIDTH{1'b1}};
      case (mode)
         M_WALK1: vec = one_hot;
         M_WALK0: vec = ~one_hot;
         M_LFSR:  vec = lfsr_d;
         default: vec = {WIDTH{1'b1}};
      endcase
   end

endmodule

// File: rtl/vcd_stim_sequencer.sv
// rtl/vcd_stim_sequencer.sv - steps pattern vectors onto the detector and accumulates its response
module vcd_stim_sequencer #(
   parameter int          WIDTH     = 64,
   parameter int          HOLD_CYC  = 4,
   parameter int          NUM_VEC   = 256,
   parameter int          CNT_W     = 16,
   parameter logic [63:0] LFSR_SEED = 64'h0000_0000_0000_0001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             abort,
   input  logic             y_in,
   output logic [WIDTH-1:0] dut_a,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_idx,
   output logic [CNT_W-1:0] y_ones,
   output logic [CNT_W-1:0] y_toggles
);

   import vcd_stim_pkg::*;

   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LAST_WALK = CNT_W'(63);
   localparam logic [CNT_W-1:0] LAST_NV   = CNT_W'(NUM_VEC - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t          state;
   mode_t           mode_q;
   mode_t           mode_sel;
   logic [HW-1:0]   hold;
   logic            samp_valid;
   logic            prev_y;
   logic            accept;
   logic            last_vec;
   logic            lfsr_step;
   logic [5:0]      pat_index;
   logic [WIDTH-1:0] pat_vec;

   assign accept    = (state == IDLE) && start;
   assign last_vec  = vec_idx == ((mode_q inside {M_WALK1, M_WALK0}) ? LAST_WALK : LAST_NV);
   assign lfsr_step = (state == DRIVE) && !abort && (hold == HOLD_LAST) && !last_vec;
   // vector 0 is generated from the mode port directly so it lands on the first DRIVE cycle
   assign mode_sel  = accept ? mode_t'(mode) : mode_q;
   assign pat_index = accept ? 6'd0 : vec_idx[5:0] + 6'd1;

   vcd_pattern_gen #(.LFSR_SEED(LFSR_SEED)) u_pattern_gen (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode_sel),
      .index     (pat_index),
      .lfsr_step (lfsr_step),
      .lfsr_load (accept),
      .vec       (pat_vec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mode_q     <= M_WALK1;
         hold       <= '0;
         samp_valid <= 1'b0;
         prev_y     <= 1'b0;
         dut_a      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_idx    <= '0;
         y_ones     <= '0;
         y_toggles  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= DRIVE;
                  mode_q     <= mode_t'(mode);
                  busy       <= 1'b1;
                  dut_a      <= pat_vec;
                  hold       <= '0;
                  samp_valid <= 1'b0;
                  vec_idx    <= '0;
                  y_ones     <= '0;
                  y_toggles  <= '0;
               end
            end
            DRIVE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  dut_a <= '0;
               end else if (hold == HOLD_LAST) begin
                  hold       <= '0;
                  prev_y     <= y_in;
                  samp_valid <= 1'b1;
                  if (y_in)
                     y_ones <= sat_inc(y_ones);
                  if (samp_valid && (y_in != prev_y))
                     y_toggles <= sat_inc(y_toggles);
                  if (last_vec) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     dut_a <= '0;
                  end else begin
                     vec_idx <= sat_inc(vec_idx);
                     dut_a   <= pat_vec;
                  end
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vcd_stim_sequencer.sv
// tb/tb_vcd_stim_sequencer.sv - self-checking bench for vcd_stim_sequencer
module tb_vcd_stim_sequencer;

   localparam int H  = 4;
   localparam int NV = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        y_sel = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        y_in;
   logic [63:0] dut_a;
   logic        busy;
   logic        done;
   logic [15:0] vec_idx;
   logic [15:0] y_ones;
   logic [15:0] y_toggles;

   int checks = 0;
   int passed = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   // detector: Y=0 only when bit 63 is set and the vector is not all-ones
   function automatic logic det(input logic [63:0] a);
      return ~a[63] | (&a);
   endfunction

   assign y_in = y_sel ? dut_a[0] : det(dut_a);

   vcd_stim_sequencer #(
      .WIDTH(64), .HOLD_CYC(H), .NUM_VEC(NV), .CNT_W(16), .LFSR_SEED(64'h1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .y_in(y_in),
      .dut_a(dut_a), .busy(busy), .done(done), .vec_idx(vec_idx),
      .y_ones(y_ones), .y_toggles(y_toggles)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] lfsr_tab [NV];
   int e_st = 0;            // 0 idle, 1 drive, 2 done
   int e_mode = 0, e_t = 0, e_idx = 0, e_ones = 0, e_tog = 0;
   bit e_valid = 1'b0, e_prev = 1'b0;

   function automatic int vec_count(input int m);
      return (m < 2) ? 64 : NV;
   endfunction

   function automatic logic [63:0] pat(input int m, input int i);
      logic [63:0] one;
      one = 64'h1;
      case (m)
         0: return one << i;
         1: return ~(one << i);
         2: return lfsr_tab[i];
         default: return '1;
      endcase
   endfunction

   task automatic model_step();
      logic [63:0] v;
      bit y;
      if (rst) begin
         e_st = 0; e_idx = 0; e_ones = 0; e_tog = 0; e_valid = 0; e_prev = 0;
      end else begin
         case (e_st)
            0: if (start) begin
               e_st = 1; e_mode = int'(mode); e_t = 0; e_idx = 0;
               e_ones = 0; e_tog = 0; e_valid = 0;
            end
            1: if (abort) e_st = 0;
               else begin
                  if (e_t % H == H - 1) begin
                     v = pat(e_mode, e_t / H);
                     y = y_sel ? v[0] : det(v);
                     if (y && e_ones < 65535) e_ones++;
                     if (e_valid && y != e_prev && e_tog < 65535) e_tog++;
                     e_prev = y; e_valid = 1;
                     if (e_t / H == vec_count(e_mode) - 1) e_st = 2;
                  end
                  if (e_st == 1) begin
                     e_t++;
                     e_idx = e_t / H;
                  end
               end
            default: e_st = 0;
         endcase
      end
   endtask

   initial begin
      lfsr_tab[0] = 64'h1;
      for (int i = 1; i < NV; i++)
         lfsr_tab[i] = (lfsr_tab[i-1] >> 1) ^ (lfsr_tab[i-1][0] ? 64'hD800_0000_0000_0000 : 64'h0);
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("cyc_busy", busy, e_st == 1);
            check("cyc_done", done, e_st == 2);
            check("cyc_dut_a", dut_a, (e_st == 1) ? pat(e_mode, e_t / H) : 64'h0);
            check("cyc_vec_idx", vec_idx, e_idx);
            check("cyc_y_ones", y_ones, e_ones);
            check("cyc_y_toggles", y_toggles, e_tog);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input logic [1:0] m, output int bc, output int dc,
                          output logic [63:0] v0, output logic [63:0] v1,
                          output logic [63:0] v2, output logic [63:0] v5);
      bit seen;
      bc = 0; dc = 0; seen = 0;
      v0 = 'x; v1 = 'x; v2 = 'x; v5 = 'x;
      start = 1'b1; mode = m;
      tick();
      start = 1'b0; mode = ~m;
      for (int k = 0; k < 3000; k++) begin
         if (k == 0)     v0 = dut_a;
         if (k == H)     v1 = dut_a;
         if (k == 2 * H) v2 = dut_a;
         if (k == 5 * H) v5 = dut_a;
         if (busy) bc++;
         if (done) begin
            dc++; seen = 1;
            break;
         end
         tick();
      end
      if (!seen) check("seq_timeout", 0, 1);
      repeat (3) begin
         tick();
         if (done) dc++;
      end
   endtask

   int bc, dc;
   logic [63:0] v0, v1, v2, v5;

   initial begin
      repeat (3) tick();
      check("rst_dut_a", dut_a, 64'h0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_vec_idx", vec_idx, 0);
      check("rst_y_ones", y_ones, 0);
      check("rst_y_toggles", y_toggles, 0);
      check("model_lfsr1", lfsr_tab[1], 64'hD800_0000_0000_0000);
      check("model_lfsr2", lfsr_tab[2], 64'h6C00_0000_0000_0000);
      rst = 1'b0;
      cmp_en = 1'b1;
      tick();

      // mode 0 walking one
      run_seq(2'd0, bc, dc, v0, v1, v2, v5);
      check("m0_busy_cycles", bc, 256);
      check("m0_done_pulses", dc, 1);
      check("m0_y_ones", y_ones, 63);
      check("m0_y_toggles", y_toggles, 1);
      check("m0_vec_idx", vec_idx, 63);

      // mode 1 walking zero
      run_seq(2'd1, bc, dc, v0, v1, v2, v5);
      check("m1_vec5", v5, 64'hFFFF_FFFF_FFFF_FFDF);
      check("m1_y_ones", y_ones, 1);
      check("m1_y_toggles", y_toggles, 1);
      check("m1_done_pulses", dc, 1);

      // mode 3 all-ones
      run_seq(2'd3, bc, dc, v0, v1, v2, v5);
      check("m3_busy_cycles", bc, 1024);
      check("m3_y_ones", y_ones, 256);
      check("m3_y_toggles", y_toggles, 0);
      check("m3_dut_a_after", dut_a, 64'h0);

      // mode 2 LFSR with y tied to dut_a[0]
      y_sel = 1'b1;
      run_seq(2'd2, bc, dc, v0, v1, v2, v5);
      check("m2_vec0", v0, 64'h1);
      check("m2_vec1", v1, 64'hD800_0000_0000_0000);
      check("m2_vec2", v2, 64'h6C00_0000_0000_0000);
      check("m2_busy_cycles", bc, 1024);
      check("m2_y_toggles", y_toggles, e_tog);
      y_sel = 1'b0;

      // abort at vector 10, with an ignored start while busy
      start = 1'b1; mode = 2'd0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 200 && vec_idx != 16'd5; k++) tick();
      start = 1'b1; mode = 2'd3;
      tick();
      start = 1'b0;
      check("busy_start_ignored", dut_a, 64'h20);
      for (int k = 0; k < 200 && vec_idx != 16'd10; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_y_ones", y_ones, 10);
      check("abort_vec_idx", vec_idx, 10);
      dc = 0;
      repeat (4) begin
         if (done) dc++;
         tick();
      end
      check("abort_no_done", dc, 0);

      // start and abort together in IDLE: start wins, counts cleared
      start = 1'b1; abort = 1'b1; mode = 2'd3;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_wins_busy", busy, 1);
      check("fresh_y_ones", y_ones, 0);
      check("fresh_vec_idx", vec_idx, 0);
      check("fresh_dut_a", dut_a, 64'hFFFF_FFFF_FFFF_FFFF);

      // reset mid-sequence
      repeat (30) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_dut_a", dut_a, 64'h0);
      check("midrst_y_ones", y_ones, 0);
      check("midrst_vec_idx", vec_idx, 0);
      check("midrst_done", done, 0);
      tick();
      run_seq(2'd0, bc, dc, v0, v1, v2, v5);
      check("post_rst_busy_cycles", bc, 256);
      check("post_rst_done_pulses", dc, 1);
      check("post_rst_y_ones", y_ones, 63);
      check("post_rst_y_toggles", y_toggles, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vcd_stim_sequencer.md
Name: vcd_stim_sequencer

Overview:
- Self-running stimulus controller for the 64-input detector netlist (`fast_dut_A[63:0]` in, `fast_dut_Y` out).
- Steps a registered 64-bit vector through a selected pattern mode and holds each vector for a fixed number of cycles.
- Samples the detector output once per vector and accumulates ones and toggle counts.
- Produces deterministic switching activity for VCD-driven power and activity checks, and gives the testbench a pass/fail signature.

Parameters:
- WIDTH, 64, detector input width; patterns are defined for 64 only.
- HOLD_CYC, 4, cycles each vector is held on dut_a; legal values are 1 or more.
- NUM_VEC, 256, vector count for the LFSR and constant modes.
- CNT_W, 16, width of the index and result counters.
- LFSR_SEED, 64'h0000_0000_0000_0001, LFSR start value; a seed of zero is replaced by all-ones.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- mode  in  2  pattern select, sampled when start is accepted: 0 walking-one, 1 walking-zero, 2 LFSR, 3 all-ones constant.
- abort  in  1  stops the sequence early.
- y_in  in  1  detector output, driven combinationally from dut_a.
- dut_a  out  WIDTH  registered stimulus to the detector input.
- busy  out  1  high in DRIVE.
- done  out  1  one-cycle pulse when a sequence completes normally.
- vec_idx  out  CNT_W  index of the current vector.
- y_ones  out  CNT_W  number of samples where y_in=1.
- y_toggles  out  CNT_W  number of samples that differ from the previous sample.

Behaviour:
- Reset values: all outputs 0. Internal state: IDLE, sample-valid flag cleared, LFSR loaded with the effective seed.
- IDLE:
  - dut_a=0, busy=0.
  - start=1 latches mode, clears vec_idx, y_ones, y_toggles and the sample-valid flag, reloads the LFSR, and moves to DRIVE.
  - dut_a shows vector 0 in the cycle after start.
- DRIVE:
  - busy=1. A hold counter runs 0 to HOLD_CYC-1.
  - On the edge where hold=HOLD_CYC-1, y_in is sampled:
    - y_ones increments if y_in=1.
    - y_toggles increments if the sample-valid flag is set and y_in differs from the stored previous sample.
    - The sample is stored and the sample-valid flag is set.
  - On that same edge:
    - If vec_idx is the last vector, go to DONE.
    - Otherwise vec_idx increments and dut_a loads the next vector.
- Vector count per sequence: 64 for modes 0 and 1, NUM_VEC for modes 2 and 3.
- Sequence length: exactly count × HOLD_CYC cycles in DRIVE.
- Patterns for vector i:
  - mode 0: 1<<i.
  - mode 1: ~(1<<i).
  - mode 2: current LFSR value, advanced once per vector. 64-bit Galois LFSR shifting right; when bit0=1, XOR with 64'hD800_0000_0000_0000.
  - mode 3: all-ones.
- DONE: lasts one cycle. done=1, busy=0, dut_a=0, then return to IDLE. Results hold until the next accepted start.
- Counters saturate at 2^CNT_W-1; they never wrap.
- start while busy is ignored.
- abort in DRIVE: next cycle is IDLE, with no done pulse and partial counts retained. abort in IDLE or DONE has no effect.
- abort and start in the same IDLE cycle: start wins.
- rst at any time, including mid-sequence: next cycle matches the reset values; no done pulse.
- mode changes after start acceptance have no effect on the running sequence.

Decomposition:
- Package vcd_stim_pkg holds:
  - state enum {IDLE, DRIVE, DONE};
  - mode enum {M_WALK1, M_WALK0, M_LFSR, M_ONES};
  - LFSR_TAPS constant;
  - WIDTH constant.
- Sub-module vcd_pattern_gen:
  - inputs: mode, index, lfsr_step, lfsr_load;
  - output: the next 64-bit vector;
  - owns the LFSR register.
- The sequencer owns the FSM, hold counter, sampling and result counters.

Test Plan:
- Mode 0, HOLD_CYC=4, real detector netlist on dut_a → busy for 256 cycles; done 1 pulse; y_ones=63 (Y=0 only when bit 63 alone is set); y_toggles=1.
- Mode 1 → y_ones=1 (Y=1 only when bit 63 is cleared); y_toggles=1; dut_a at vector 5 = 64'hFFFF_FFFF_FFFF_FFDF.
- Mode 3, NUM_VEC=256 → y_ones=256, y_toggles=0; dut_a stays all-ones for 1024 cycles, then returns to 0.
- Mode 2, seed 1 → first three dut_a values are 64'h1, 64'hD800_0000_0000_0000, 64'h6C00_0000_0000_0000; y_in tied to dut_a[0] → toggle count matches the bench LFSR model.
- Abort at vec_idx=10 in mode 0 → IDLE next cycle; no done; y_ones=10, vec_idx=10. A second start is ignored while busy, and a fresh start afterwards clears all counts.
- rst asserted mid-DRIVE → all outputs 0 next cycle; the following start behaves identically to one issued after power-up.
